// File: rtl/parity_gen_chk_if.sv
// Parity generator/checker bus: strobes and data in from the UART datapath, parity results out.
interface parity_gen_chk_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 8
);
   logic                  PAR_EN;
   logic [1:0]            PAR_TYP;
   logic                  DATA_VALID;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  SER_EN;
   logic                  SER_BIT;
   logic                  CHK_STB;
   logic                  RX_PAR_BIT;
   logic                  CLR_ERR;
   logic                  par_bit;
   logic                  par_done;
   logic                  par_err;
   logic [CNT_WIDTH-1:0]  err_cnt;

   modport master (
      output PAR_EN, PAR_TYP, DATA_VALID, P_DATA, SER_EN, SER_BIT, CHK_STB, RX_PAR_BIT, CLR_ERR,
      input  par_bit, par_done, par_err, err_cnt
   );

   modport slave (
      input  PAR_EN, PAR_TYP, DATA_VALID, P_DATA, SER_EN, SER_BIT, CHK_STB, RX_PAR_BIT, CLR_ERR,
      output par_bit, par_done, par_err, err_cnt
   );
endinterface

// File: rtl/parity_gen_chk.sv
// UART parity generator/checker: parallel or bit-serial parity with RX compare and error tracking.
// Define PARITY_ERR_CNT_EN to build the saturating error counter; otherwise err_cnt reads 0.
module parity_gen_chk #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input logic              CLK,
   input logic              RST,
   parity_gen_chk_if.slave  bus
);
   localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StAccum, StReady} state_e;

   state_e            state_q, state_d;
   logic              par_bit_q, par_bit_d;
   logic              par_done_q, par_done_d;
   logic              par_err_q, par_err_d;
   logic              acc_q, acc_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [CntW-1:0]   cnt_inc;
   logic              mismatch;

   // Final parity bit from the raw XOR of the data word.
   function automatic logic par_f(input logic x, input logic [1:0] typ);
      unique case (typ)
         2'b00:   return x;
         2'b01:   return ~x;
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign cnt_inc = cnt_q + CntW'(1);

   always_comb begin
      state_d    = state_q;
      par_bit_d  = par_bit_q;
      par_done_d = 1'b0;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      mismatch   = 1'b0;

      if (!bus.PAR_EN) begin
         state_d   = StIdle;
         par_bit_d = 1'b0;
         cnt_d     = '0;
      end else if (bus.DATA_VALID) begin
         par_bit_d  = par_f(^bus.P_DATA, bus.PAR_TYP);
         par_done_d = 1'b1;
         cnt_d      = '0;
         state_d    = StReady;
      end else if (bus.SER_EN) begin
         if (state_q == StAccum) begin
            acc_d = acc_q ^ bus.SER_BIT;
            cnt_d = cnt_inc;
            if (cnt_inc == CntW'(DATA_WIDTH)) begin
               par_bit_d  = par_f(acc_q ^ bus.SER_BIT, bus.PAR_TYP);
               par_done_d = 1'b1;
               cnt_d      = '0;
               state_d    = StReady;
            end
         end else begin
            acc_d   = bus.SER_BIT;
            cnt_d   = CntW'(1);
            state_d = StAccum;
         end
      end else if (bus.CHK_STB && state_q == StReady) begin
         mismatch = bus.RX_PAR_BIT != par_bit_q;
         state_d  = StIdle;
      end

      // A mismatch in the same cycle as a clear wins over the clear.
      par_err_d = bus.CLR_ERR ? 1'b0 : par_err_q;
      if (mismatch) par_err_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= StIdle;
         par_bit_q  <= 1'b0;
         par_done_q <= 1'b0;
         par_err_q  <= 1'b0;
         acc_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         par_bit_q  <= par_bit_d;
         par_done_q <= par_done_d;
         par_err_q  <= par_err_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = bus.CLR_ERR ? '0 : err_cnt_q;
      if (mismatch && err_cnt_d != {CNT_WIDTH{1'b1}}) err_cnt_d = err_cnt_d + CNT_WIDTH'(1);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) err_cnt_q <= '0;
      else      err_cnt_q <= err_cnt_d;
   end

   assign bus.err_cnt = err_cnt_q;
`else
   assign bus.err_cnt = {CNT_WIDTH{1'b0}};
`endif

   assign bus.par_bit  = par_bit_q;
   assign bus.par_done = par_done_q;
   assign bus.par_err  = par_err_q;
endmodule

// File: doc/parity_gen_chk.md
Name: parity_gen_chk

Overview:
- Parametrised parity generator/checker for the UART datapath.
- Computes parity over a DATA_WIDTH word, either in one cycle (parallel load) or bit-by-bit while a serializer or deserializer shifts.
- Supports even, odd, mark and space parity.
- Also checks a received parity bit against the computed one, with a sticky error flag and a saturating error counter. Serves both the TX frame builder and the RX checker.

Parameters:
- DATA_WIDTH, 8, number of data bits covered by parity (legal range 5..16).
- CNT_WIDTH, 8, width of the parity error counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- PAR_EN  input  1  1 = parity enabled; 0 = block idle, par_bit forced 0.
- PAR_TYP  input  2  00 even, 01 odd, 10 mark (constant 1), 11 space (constant 0).
- DATA_VALID  input  1  parallel load strobe for P_DATA.
- P_DATA  input  DATA_WIDTH  parallel data word.
- SER_EN  input  1  serial accumulate strobe, one data bit per strobe.
- SER_BIT  input  1  serial data bit.
- CHK_STB  input  1  compare strobe for RX_PAR_BIT.
- RX_PAR_BIT  input  1  received parity bit.
- CLR_ERR  input  1  clears par_err and err_cnt.
- par_bit  output  1  computed parity bit, registered.
- par_done  output  1  one-cycle pulse when par_bit is final.
- par_err  output  1  sticky mismatch flag.
- err_cnt  output  CNT_WIDTH  saturating mismatch count.

Behaviour:
- Reset (RST=0, async) sets: state IDLE, par_bit=0, par_done=0, par_err=0, err_cnt=0, accumulator=0, bit counter=0.
- States: IDLE, ACCUM, READY. par_done defaults to 0 every cycle.
- IDLE, DATA_VALID=1:
  - par_bit <= f(P_DATA, PAR_TYP); par_done=1 on the next cycle; go to READY. Latency 1 cycle.
  - f: even = XOR of all bits; odd = XNOR of all bits; mark = 1; space = 0.
- IDLE, SER_EN=1 (DATA_VALID=0): accumulator <= SER_BIT, counter <= 1, go to ACCUM.
- ACCUM, SER_EN=1:
  - accumulator <= accumulator ^ SER_BIT; counter increments.
  - On the strobe where counter reaches DATA_WIDTH: par_bit <= f(accumulated XOR, PAR_TYP), par_done=1 next cycle, counter cleared, go to READY.
  - Cycles with SER_EN=0 hold state; gaps between strobes are unbounded.
- PAR_TYP sampling: sampled only at the finalising cycle (parallel load or last serial bit). par_bit holds its value otherwise.
- READY:
  - par_bit is held.
  - CHK_STB=1: a mismatch (RX_PAR_BIT != par_bit) sets par_err=1 and increments err_cnt. Return to IDLE whether or not there is a mismatch.
  - DATA_VALID=1 or SER_EN=1 without CHK_STB starts a new word, as from IDLE (TX use needs no check).
- Priority: DATA_VALID > SER_EN > CHK_STB.
  - DATA_VALID during ACCUM aborts the serial word, clears the counter and performs a parallel load.
  - CHK_STB in IDLE or ACCUM is ignored.
- err_cnt saturates at 2^CNT_WIDTH-1; par_err stays set.
- CLR_ERR=1 clears par_err and err_cnt. If a mismatch is detected in the same cycle, the result is par_err=1, err_cnt=1.
- PAR_EN=0:
  - Synchronously forces IDLE, par_bit=0, counter=0; all strobes are ignored.
  - par_err and err_cnt are kept.
  - Deasserting PAR_EN mid-ACCUM discards the partial word.
- Reset mid-operation: immediate return to reset values; no par_done is emitted.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined: err_cnt counter implemented as specified.
- Not defined: no counter register; err_cnt is tied to 0. par_err and all other behaviour are unchanged.

Test Plan:
- Parallel load, DATA_WIDTH=8, reset released:
  - P_DATA=0xA5, PAR_TYP=00 -> par_bit=0, par_done pulse 1 cycle after DATA_VALID.
  - PAR_TYP=01 -> par_bit=1.
  - P_DATA=0x07, PAR_TYP=00 -> par_bit=1.
- Serial: 8 SER_EN strobes of 0x07 LSB-first with random gaps, PAR_TYP=01 -> par_bit=0 only after the 8th strobe, single par_done pulse. Mark/space give 1/0 regardless of data.
- Check: after par_bit=1, CHK_STB with RX_PAR_BIT=0 -> par_err=1, err_cnt=1. A matching check leaves both unchanged. CLR_ERR together with a mismatch -> par_err=1, err_cnt=1.
- Saturation: CNT_WIDTH=2, 5 mismatches -> err_cnt stays 3.
- Abort: DATA_VALID (0x01, even) after 3 serial bits -> par_bit=1, no stale serial completion afterwards. PAR_EN=0 mid-ACCUM -> par_bit=0, no par_done.
- Reset mid-ACCUM: RST low asynchronously -> all outputs 0 immediately. A fresh 8-bit serial word afterwards computes correctly.
